// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, MUL/DIV occupancy of EX,
// EX-stage forwarding selects and saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             ResultSrcE0,
  input  logic             MulDivE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned CW = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  logic [1:0]       state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             lw_stall;
  logic             apply_flow;

  // MEM result is younger than WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWriteM && (RdM != 5'd0) && (RdM == rs)) begin
      return FWD_MEM;
    end else if (RegWriteW && (RdW != 5'd0) && (RdW == rs)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

  assign lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    apply_flow = 1'b0;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushM     = 1'b0;
    ForwardAE  = FWD_RF;
    ForwardBE  = FWD_RF;
    md_done    = 1'b0;
    if (reset) begin
      ForwardAE = fwd_sel(Rs1E);
      ForwardBE = fwd_sel(Rs2E);
      case (state)
        RUN: begin
          if (MulDivE) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
            if (MULDIV_LAT == 2) begin
              state_next = DRAIN;
            end else begin
              state_next = BUSY;
              cnt_next   = CW'(MULDIV_LAT - 3);
            end
          end else begin
            apply_flow = 1'b1;
          end
        end
        BUSY: begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          FlushM = 1'b1;
          if (cnt == '0) begin
            state_next = DRAIN;
          end else begin
            cnt_next = cnt - 1'b1;
          end
        end
        DRAIN: begin
          md_done    = 1'b1;
          apply_flow = 1'b1;
          state_next = RUN;
        end
        default: state_next = RUN;
      endcase
      // Branch redirect beats a load-use stall: the stalled instruction is squashed anyway.
      if (apply_flow) begin
        if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (lw_stall) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= RUN;
      cnt     <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (StallF && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (FlushE && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = reset ? stall_q : '0;
  assign flush_cnt = reset ? flush_q : '0;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic against
// a cycle-level reference model that tracks MUL/DIV progress as "cycles spent in EX".
module tb_hazard_ctrl;

  localparam int unsigned LAT  = 4;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          ResultSrcE0, MulDivE, PCSrcE, RegWriteM, RegWriteW;
  logic          StallF, StallD, StallE, FlushD, FlushE, FlushM, md_done;
  logic [1:0]    ForwardAE, ForwardBE;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  int k_spent = 0;
  int m_stall = 0;
  int m_flush = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .MulDivE(MulDivE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .md_done(md_done),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int fwd_ref(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2;
    if (RegWriteW && RdW != 0 && RdW == rs) return 1;
    return 0;
  endfunction

  task automatic clear_inputs();
    reset = 1'b1;
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {ResultSrcE0, MulDivE, PCSrcE, RegWriteM, RegWriteW} = '0;
  endtask

  // Inputs are set by the caller just after a rising edge; outputs checked mid-cycle.
  task automatic step();
    int e_sf, e_sd, e_se, e_fd, e_fe, e_fm, e_a, e_b, e_done, e_sc, e_fc, pos;
    bit lw;
    #3;
    {e_sf, e_sd, e_se, e_fd, e_fe, e_fm, e_a, e_b, e_done, e_sc, e_fc} = '0;
    pos = 0;
    if (reset) begin
      e_a  = fwd_ref(Rs1E);
      e_b  = fwd_ref(Rs2E);
      lw   = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      if (k_spent > 0 || MulDivE) pos = k_spent + 1;
      if (pos != 0 && pos < LAT) begin
        e_sf = 1; e_sd = 1; e_se = 1; e_fm = 1;
      end else begin
        e_done = (pos == LAT);
        if (PCSrcE) begin
          e_fd = 1; e_fe = 1;
        end else if (lw) begin
          e_sf = 1; e_sd = 1; e_fe = 1;
        end
      end
      e_sc = m_stall;
      e_fc = m_flush;
    end
    chk("StallF", 32'(StallF), 32'(e_sf));
    chk("StallD", 32'(StallD), 32'(e_sd));
    chk("StallE", 32'(StallE), 32'(e_se));
    chk("FlushD", 32'(FlushD), 32'(e_fd));
    chk("FlushE", 32'(FlushE), 32'(e_fe));
    chk("FlushM", 32'(FlushM), 32'(e_fm));
    chk("ForwardAE", 32'(ForwardAE), 32'(e_a));
    chk("ForwardBE", 32'(ForwardBE), 32'(e_b));
    chk("md_done", 32'(md_done), 32'(e_done));
    chk("stall_cnt", 32'(stall_cnt), 32'(e_sc));
    chk("flush_cnt", 32'(flush_cnt), 32'(e_fc));
    if (!reset) begin
      k_spent = 0; m_stall = 0; m_flush = 0;
    end else begin
      k_spent = (pos != 0 && pos < LAT) ? pos : 0;
      if (e_sf != 0 && m_stall < CMAX) m_stall++;
      if (e_fe != 0 && m_flush < CMAX) m_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    ResultSrcE0 = 1'b1; Rs1D = 5'd5; RdE = 5'd5;
    step();
    step();

    // MUL/DIV held high: LAT-1 stall cycles, then drain without retrigger
    clear_inputs();
    MulDivE = 1'b1;
    repeat (LAT) step();
    MulDivE = 1'b0;
    step();
    chk("t4_stall_cnt", 32'(stall_cnt), 32'(LAT - 1));

    // Load-use stall, then zero destination, then branch on top
    clear_inputs();
    Rs1D = 5'd5; RdE = 5'd5; ResultSrcE0 = 1'b1;
    step();
    RdE = 5'd0;
    step();
    PCSrcE = 1'b1;
    step();
    RdE = 5'd5;
    step();

    // Forwarding priority
    clear_inputs();
    RdM = 5'd7; RdW = 5'd7; RegWriteM = 1'b1; RegWriteW = 1'b1; Rs1E = 5'd7; Rs2E = 5'd7;
    step();
    chk("t3_fwd_mem", 32'(ForwardAE), 32'd2);
    RegWriteM = 1'b0;
    step();
    chk("t3_fwd_wb", 32'(ForwardAE), 32'd1);

    // Reset abandons an in-flight MUL/DIV
    clear_inputs();
    MulDivE = 1'b1;
    step();
    MulDivE = 1'b0;
    step();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    chk("t5_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("t5_flush_cnt", 32'(flush_cnt), 32'd0);

    // Counter saturation
    Rs1D = 5'd5; RdE = 5'd5; ResultSrcE0 = 1'b1;
    repeat (20) step();
    chk("t6_stall_sat", 32'(stall_cnt), 32'(CMAX));
    chk("t6_flush_sat", 32'(flush_cnt), 32'(CMAX));

    // Random traffic with a small register pool to provoke frequent hazards
    repeat (600) begin
      reset       = ($urandom_range(0, 59) != 0);
      Rs1D        = 5'($urandom_range(0, 3));
      Rs2D        = 5'($urandom_range(0, 3));
      Rs1E        = 5'($urandom_range(0, 3));
      Rs2E        = 5'($urandom_range(0, 3));
      RdE         = 5'($urandom_range(0, 3));
      RdM         = 5'($urandom_range(0, 3));
      RdW         = 5'($urandom_range(0, 3));
      ResultSrcE0 = 1'($urandom_range(0, 1));
      RegWriteM   = 1'($urandom_range(0, 1));
      RegWriteW   = 1'($urandom_range(0, 1));
      MulDivE     = ($urandom_range(0, 7) == 0);
      PCSrcE      = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
